// File: rtl/prog_loader.sv
`default_nettype none
// =============================================================================
// Module : prog_loader
// Brief  : Zero-fills instruction memory, streams a program into it, releases
//          the CPU from reset and stops it on a halt self-loop or a timeout.
// Rev    : 1.0
// =============================================================================
module prog_loader #(
    parameter int               XLEN      = 32,
    parameter int               DEPTH     = 1024,
    parameter int               RST_HOLD  = 4,
    parameter int               TIMEOUT   = 250,
    parameter logic [XLEN-1:0]  HALT_WORD = 32'h0000006f,
    parameter int               HALT_CNT  = 3,
    localparam int              AW        = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [XLEN-1:0] ld_data,
    input  logic            ld_last,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            cpu_rst,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_instr,
    output logic            busy,
    output logic            done,
    output logic            timeout,
    output logic            ovf,
    output logic [31:0]     cycles,
    output logic [AW:0]     words
);

    localparam int AW1 = AW + 1;
    localparam int HW  = $clog2(HALT_CNT + 1);
    localparam int RW  = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_CLEAR   = 3'd1;
    localparam logic [2:0] c_LOAD    = 3'd2;
    localparam logic [2:0] c_RELEASE = 3'd3;
    localparam logic [2:0] c_RUN     = 3'd4;
    localparam logic [2:0] c_DONE    = 3'd5;

    localparam logic [AW-1:0] c_LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   c_LAST_WORD = AW1'(DEPTH - 1);
    localparam logic [RW-1:0] c_HOLD_LAST = RW'(RST_HOLD - 1);
    localparam logic [HW-1:0] c_HALT_CNT  = HW'(HALT_CNT);
    localparam logic [31:0]   c_TIMEOUT   = 32'(TIMEOUT);

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [AW-1:0]   r_clr;
    logic [AW:0]     r_words;
    logic [RW-1:0]   r_hold;
    logic [HW-1:0]   r_hcnt;
    logic [31:0]     r_cycles;
    logic            r_timeout;
    logic            r_ovf;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;

    logic w_hs;
    logic w_load_end;
    logic w_halt_hit;
    logic w_to;

    assign w_hs       = ld_valid && (r_state == c_LOAD);
    assign w_load_end = w_hs && (ld_last || (r_words == c_LAST_WORD));
    // Halt fires on the observation that completes the run of HALT_CNT.
    assign w_halt_hit = if_valid && (if_instr == HALT_WORD) && ((r_hcnt + 1'b1) == c_HALT_CNT);
    assign w_to       = (r_cycles >= c_TIMEOUT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE, c_DONE: if (start)                   w_next = c_CLEAR;
            c_CLEAR:        if (r_clr == c_LAST_ADDR)    w_next = c_LOAD;
            c_LOAD:         if (w_load_end)              w_next = c_RELEASE;
            c_RELEASE:      if (r_hold == c_HOLD_LAST)   w_next = c_RUN;
            c_RUN:          if (w_halt_hit || w_to)      w_next = c_DONE;
            default:                                     w_next = c_IDLE;
        endcase
    end

    always_comb begin
        ld_ready = 1'b0;
        busy     = 1'b0;
        cpu_rst  = 1'b1;
        done     = 1'b0;
        case (r_state)
            c_CLEAR, c_RELEASE: busy = 1'b1;
            c_LOAD: begin
                busy     = 1'b1;
                ld_ready = 1'b1;
            end
            c_RUN: begin
                busy    = 1'b1;
                cpu_rst = 1'b0;
            end
            c_DONE: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clr       <= '0;
            r_words     <= '0;
            r_hold      <= '0;
            r_hcnt      <= '0;
            r_cycles    <= '0;
            r_timeout   <= 1'b0;
            r_ovf       <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_clr     <= '0;
                        r_words   <= '0;
                        r_hold    <= '0;
                        r_hcnt    <= '0;
                        r_cycles  <= '0;
                        r_timeout <= 1'b0;
                        r_ovf     <= 1'b0;
                    end
                end
                c_CLEAR: begin
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= r_clr;
                    r_mem_wdata <= '0;
                    r_clr       <= r_clr + 1'b1;
                end
                c_LOAD: begin
                    if (w_hs) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_words[AW-1:0];
                        r_mem_wdata <= ld_data;
                        r_words     <= r_words + 1'b1;
                        if (!ld_last && (r_words == c_LAST_WORD))
                            r_ovf <= 1'b1;
                    end
                end
                c_RELEASE: begin
                    // Preload so the first RUN cycle already reports 1.
                    if (r_hold == c_HOLD_LAST)
                        r_cycles <= 32'd1;
                    r_hold <= r_hold + 1'b1;
                end
                c_RUN: begin
                    if (if_valid)
                        r_hcnt <= (if_instr == HALT_WORD) ? r_hcnt + 1'b1 : '0;
                    if (w_halt_hit)
                        r_timeout <= 1'b0;
                    else if (w_to)
                        r_timeout <= 1'b1;
                    else if (r_cycles != 32'hFFFF_FFFF)
                        r_cycles <= r_cycles + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign timeout   = r_timeout;
    assign ovf       = r_ovf;
    assign cycles    = r_cycles;
    assign words     = r_words;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// =============================================================================
// Module : tb_prog_loader
// Brief  : Random program loads and runs of prog_loader against a phase model.
// Rev    : 1.0
// =============================================================================
module tb_prog_loader;

    localparam int          DEPTH     = 16;
    localparam int          AW        = 4;
    localparam int          RST_HOLD  = 4;
    localparam int          TIMEOUT   = 40;
    localparam int          HALT_CNT  = 2;
    localparam logic [31:0] HALT_WORD = 32'h0000006f;
    localparam logic [31:0] NOP       = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_last = 1'b0;
    logic [31:0] ld_data = '0;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = '0;

    logic          ld_ready, mem_we, cpu_rst, busy, done, timeout, ovf;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, cycles;
    logic [AW:0]   words;

    prog_loader #(
        .XLEN(32), .DEPTH(DEPTH), .RST_HOLD(RST_HOLD), .TIMEOUT(TIMEOUT),
        .HALT_WORD(HALT_WORD), .HALT_CNT(HALT_CNT)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .if_valid(if_valid), .if_instr(if_instr),
        .busy(busy), .done(done), .timeout(timeout), .ovf(ovf),
        .cycles(cycles), .words(words)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Phase-level reference model, advanced once per cycle from the inputs.
    typedef enum int {P_IDLE, P_CLEAR, P_LOAD, P_RELEASE, P_RUN, P_DONE} phase_t;
    phase_t      m_phase = P_IDLE;
    int          m_cnt = 0, m_words = 0, m_halts = 0, m_addr = 0;
    logic [31:0] m_cycles = '0, m_wdata = '0;
    bit          m_ovf = 0, m_to = 0, m_we = 0;
    logic [31:0] m_mem [DEPTH];
    logic [31:0] d_mem [DEPTH];
    int          d_writes = 0;
    logic [31:0] prog_data [DEPTH+8];

    task automatic model_reset();
        m_phase = P_IDLE; m_cnt = 0; m_words = 0; m_halts = 0;
        m_cycles = '0; m_ovf = 0; m_to = 0; m_we = 0;
    endtask

    task automatic predict_write(input int a, input logic [31:0] d);
        m_we = 1; m_addr = a; m_wdata = d; m_mem[a] = d;
    endtask

    task automatic model_step();
        m_we = 0;
        case (m_phase)
            P_IDLE, P_DONE: if (start) begin
                m_phase = P_CLEAR; m_cnt = 0; m_words = 0;
                m_ovf = 0; m_to = 0; m_cycles = '0;
            end
            P_CLEAR: begin
                predict_write(m_cnt, 32'h0);
                m_cnt++;
                if (m_cnt == DEPTH) m_phase = P_LOAD;
            end
            P_LOAD: if (ld_valid) begin
                predict_write(m_words, ld_data);
                m_words++;
                if (ld_last) begin
                    m_phase = P_RELEASE; m_cnt = 0;
                end else if (m_words == DEPTH) begin
                    m_ovf = 1; m_phase = P_RELEASE; m_cnt = 0;
                end
            end
            P_RELEASE: begin
                m_cnt++;
                if (m_cnt == RST_HOLD) begin
                    m_phase = P_RUN; m_cycles = 32'd1; m_halts = 0;
                end
            end
            P_RUN: begin
                if (if_valid) m_halts = (if_instr == HALT_WORD) ? m_halts + 1 : 0;
                if (m_halts >= HALT_CNT) begin
                    m_phase = P_DONE; m_to = 0;
                end else if (m_cycles >= TIMEOUT) begin
                    m_phase = P_DONE; m_to = 1;
                end else if (m_cycles != 32'hFFFF_FFFF) begin
                    m_cycles++;
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = 32'hDEAD_BEEF;
            d_mem[i] = 32'hDEAD_BEEF;
        end
    end

    always @(negedge clk) begin
        if (!rst) model_reset();
        chk("busy",     busy,     (m_phase inside {P_CLEAR, P_LOAD, P_RELEASE, P_RUN}));
        chk("ld_ready", ld_ready, (m_phase == P_LOAD));
        chk("cpu_rst",  cpu_rst,  !(m_phase == P_RUN || m_phase == P_DONE));
        chk("done",     done,     (m_phase == P_DONE));
        chk("timeout",  timeout,  m_to);
        chk("ovf",      ovf,      m_ovf);
        chk("cycles",   cycles,   m_cycles);
        chk("words",    words,    m_words);
        chk("mem_we",   mem_we,   m_we);
        if (m_we) begin
            chk("mem_addr",  mem_addr,  m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
        if (!rst) begin
            chk("rst_mem_addr",  mem_addr,  0);
            chk("rst_mem_wdata", mem_wdata, 0);
        end
        if (mem_we) begin
            d_mem[mem_addr] = mem_wdata;
            d_writes++;
        end
        if (rst) model_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fill_prog();
        for (int i = 0; i < DEPTH + 8; i++) prog_data[i] = $urandom();
    endtask

    // Offers n words with random valid gaps; stops early on abort_at handshakes.
    task automatic load_prog(input int n, input bit with_last, input int abort_at, output int acc);
        bit hs;
        int guard;
        acc = 0;
        guard = 0;
        while (acc < n && guard < 200) begin
            ld_valid = ($urandom_range(0, 3) != 0);
            ld_data  = prog_data[acc];
            ld_last  = with_last && (acc == n - 1);
            @(negedge clk);
            hs = ld_valid && ld_ready;
            tick();
            guard++;
            if (hs) acc++;
            if (hs && !ld_ready) break;
            if (acc == abort_at) break;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic wait_run(output int edges);
        edges = 0;
        while (cpu_rst && edges < 100) begin
            tick();
            edges++;
        end
    endtask

    task automatic run_halt_at(input int k);
        for (int c = 1; c <= k + 1; c++) begin
            if (c >= k) begin
                if_valid = 1'b1;
                if_instr = HALT_WORD;
            end else begin
                if_valid = $urandom_range(0, 1) != 0;
                if_instr = $urandom();
                if (if_instr == HALT_WORD) if_instr = NOP;
            end
            tick();
        end
        if_valid = 1'b0;
    endtask

    // mode 0: strictly alternating HALT/NOP; mode 1: random with stray starts.
    task automatic run_pattern(input int mode);
        int g;
        g = 0;
        while (!done && g < 100) begin
            if (mode == 0) begin
                if_valid = 1'b1;
                if_instr = g[0] ? NOP : HALT_WORD;
            end else begin
                if_valid = $urandom_range(0, 1) != 0;
                if_instr = ($urandom_range(0, 9) < 4) ? HALT_WORD : $urandom();
                start    = ($urandom_range(0, 7) == 0);
            end
            tick();
            g++;
        end
        if_valid = 1'b0;
        start    = 1'b0;
        chk("run_ends", done, 1'b1);
    endtask

    task automatic check_image(input string tag, input int n);
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] e;
            e = (i < n) ? prog_data[i] : 32'h0;
            chk($sformatf("%s_mem[%0d]", tag, i), d_mem[i], e);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cpu_rst"},   cpu_rst,   1'b1);
        chk({tag, "_mem_we"},    mem_we,    1'b0);
        chk({tag, "_ld_ready"},  ld_ready,  1'b0);
        chk({tag, "_busy"},      busy,      1'b0);
        chk({tag, "_done"},      done,      1'b0);
        chk({tag, "_timeout"},   timeout,   1'b0);
        chk({tag, "_ovf"},       ovf,       1'b0);
        chk({tag, "_cycles"},    cycles,    32'd0);
        chk({tag, "_words"},     words,     5'd0);
        chk({tag, "_mem_addr"},  mem_addr,  4'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        int acc, edges, wbase, n;
        bit wl;

        repeat (3) tick();
        check_reset_outputs("por");
        rst = 1'b1;
        repeat (2) tick();

        // Three-word program, halt seen at RUN cycles 10 and 11.
        fill_prog();
        wbase = d_writes;
        pulse_start();
        load_prog(3, 1'b1, -1, acc);
        chk("t1_accepted", acc, 3);
        wait_run(edges);
        chk("t1_release_len", edges, RST_HOLD);
        chk("t1_words", words, 5'd3);
        run_halt_at(10);
        chk("t1_done", done, 1'b1);
        chk("t1_timeout", timeout, 1'b0);
        chk("t1_cycles", cycles, 32'd11);
        chk("t1_writes", d_writes - wbase, 19);
        check_image("t1", 3);

        // Alternating HALT/NOP never halts: timeout at 40 cycles.
        fill_prog();
        pulse_start();
        load_prog(5, 1'b1, -1, acc);
        chk("t2_accepted", acc, 5);
        wait_run(edges);
        run_pattern(0);
        chk("t2_done", done, 1'b1);
        chk("t2_timeout", timeout, 1'b1);
        chk("t2_cycles", cycles, 32'd40);
        check_image("t2", 5);

        // Twenty words without last: overflow after sixteen.
        fill_prog();
        wbase = d_writes;
        pulse_start();
        load_prog(20, 1'b0, -1, acc);
        chk("t3_accepted", acc, DEPTH);
        ld_valid = 1'b1;
        ld_data  = prog_data[DEPTH];
        repeat (3) tick();
        chk("t3_ld_ready", ld_ready, 1'b0);
        ld_valid = 1'b0;
        chk("t3_words", words, 5'd16);
        chk("t3_ovf", ovf, 1'b1);
        chk("t3_writes", d_writes - wbase, 32);
        check_image("t3", DEPTH);
        wait_run(edges);
        run_pattern(1);

        // Reset in the middle of a load, then a clean sequence afterwards.
        fill_prog();
        pulse_start();
        load_prog(10, 1'b1, 5, acc);
        chk("t4_accepted", acc, 5);
        rst = 1'b0;
        #1;
        check_reset_outputs("t4_async");
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("t4_idle_busy", busy, 1'b0);

        for (int it = 0; it < 5; it++) begin
            fill_prog();
            wl = $urandom_range(0, 3) != 0;
            n  = wl ? int'($urandom_range(1, DEPTH)) : int'($urandom_range(DEPTH, DEPTH + 4));
            pulse_start();
            load_prog(n, wl, -1, acc);
            chk($sformatf("r%0d_accepted", it), acc, wl ? n : DEPTH);
            wait_run(edges);
            chk($sformatf("r%0d_release_len", it), edges, RST_HOLD);
            check_image($sformatf("r%0d", it), acc);
            run_pattern(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
